// File: rtl/xr_boot_pkg.sv
// Shared boot-loader definitions: loader FSM states and image framing constants.
// IMEM_DEPTH is also the default capacity of the instruction memory.
package xr_boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } ld_state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_BYTES      = 4;
   localparam int IMEM_DEPTH     = 4096;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// 8-to-32 little-endian byte packer; word_valid fires on the 4th byte with the
// assembled word presented combinationally in the same cycle.
module byte_packer
   import xr_boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int CW = $clog2(BYTES_PER_WORD);

   logic [CW-1:0] cnt;
   logic [23:0]   sr;

   // Bytes enter at the top and shift down, so the first byte lands in bits 7:0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sr  <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (byte_vld) begin
         cnt <= cnt + CW'(1);
         sr  <= {byte_data, sr[23:8]};
      end
   end

   assign word_valid = byte_vld && (cnt == CW'(BYTES_PER_WORD - 1));
   assign word       = {byte_data, sr};

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction memory writer: header word count, payload words, XOR
// checksum; holds the core in reset until an image has loaded cleanly.
module inst_loader
   import xr_boot_pkg::*;
#(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = IMEM_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          s_valid,
   input  logic [7:0]    s_data,
   output logic          s_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          core_rst_n,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int KW = $clog2(DEPTH + 1);

   ld_state_e     state, state_nx;
   logic          accept, start_ok, pk_vld, word_valid, last_word;
   logic [31:0]   word;
   logic [KW-1:0] n_words, kcnt;
   logic [7:0]    csum;

   assign s_ready    = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
   assign busy       = s_ready;
   assign done       = (state == ST_DONE);
   assign err        = (state == ST_ERR);
   assign core_rst_n = done;

   assign accept    = s_valid && s_ready;
   assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
   assign pk_vld    = accept && ((state == ST_HDR) || (state == ST_DATA));
   assign last_word = (kcnt == n_words - KW'(1));

   byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (start_ok),
      .byte_vld   (pk_vld),
      .byte_data  (s_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR:
            if (start) state_nx = ST_HDR;
         ST_HDR:
            if (word_valid) begin
               if (word > 32'(DEPTH))  state_nx = ST_ERR;
               else if (word == '0)    state_nx = ST_CSUM;
               else                    state_nx = ST_DATA;
            end
         ST_DATA:
            if (word_valid && last_word) state_nx = ST_CSUM;
         ST_CSUM:
            if (accept) state_nx = (s_data == csum) ? ST_DONE : ST_ERR;
         default:
            state_nx = ST_IDLE;
      endcase
   end

   // Checksum spans header and payload; the checksum byte itself is excluded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         n_words   <= '0;
         kcnt      <= '0;
         csum      <= '0;
      end else begin
         mem_we <= 1'b0;
         if (start_ok) begin
            kcnt    <= '0;
            csum    <= '0;
            n_words <= '0;
         end
         if (pk_vld) csum <= csum ^ s_data;
         if (state == ST_HDR && word_valid) n_words <= word[KW-1:0];
         if (state == ST_DATA && word_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= AW'(kcnt) << 2;
            mem_wdata <= DW'(word);
            kcnt      <= kcnt + KW'(1);
         end
      end
   end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Boot-time writer for the instruction memory. It receives a byte stream over a valid/ready handshake, for example from a UART receiver, and packs it into little-endian 32-bit words. It writes those words to word-aligned byte addresses through the instruction memory write port. It holds the core in reset until a complete image has been loaded and checksummed, so the fetch side never reads a partial image.

Parameters:
AW, 32, byte-address width of the write port
DW, 32, data word width; fixed at 32 (4 bytes per word)
DEPTH, 4096, instruction memory capacity in words; images larger than this are rejected

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a load; honoured only in IDLE, DONE or ERR
s_valid  in  1  byte-stream valid
s_data  in  8  byte-stream data
s_ready  out  1  byte accepted when s_valid && s_ready
mem_we  out  1  instruction memory write enable, one cycle per word
mem_addr  out  AW  byte address of the written word; always a multiple of 4
mem_wdata  out  DW  word to write
core_rst_n  out  1  active-low reset to the core; low until a successful load
busy  out  1  high in HDR, DATA and CSUM
done  out  1  high in DONE
err  out  1  high in ERR

Behaviour:
- Reset values: all outputs 0. Specifically: core_rst_n=0, mem_we=0, mem_addr=0, mem_wdata=0, s_ready=0, busy=0, done=0, err=0. FSM enters IDLE.
- FSM states: IDLE, HDR, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR, start=1:
  - go to HDR; clear byte counter, word counter and checksum.
  - force core_rst_n=0 from the next cycle.
- HDR: accept 4 bytes forming N, the word count, little-endian (first byte = bits 7:0). On the 4th accepted byte:
  - N > DEPTH -> ERR.
  - N == 0 -> CSUM.
  - otherwise -> DATA.
- DATA: accept bytes into a shift register, little-endian. On each 4th byte of a word:
  - the next cycle drives mem_we=1, mem_addr = 4*k (k = word index from 0) and mem_wdata = the assembled word. These are registered outputs, so write latency is 1 cycle after the last byte's handshake.
  - after word N-1 -> CSUM.
- CSUM: accept 1 byte.
  - byte == XOR of all header and payload bytes -> DONE.
  - otherwise -> ERR.
- s_ready=1 in HDR, DATA and CSUM; otherwise 0. The loader never back-pressures mid-image; one byte per cycle sustained is legal.
- mem_we is a single-cycle pulse. Back-to-back words give mem_we at most every 4th cycle.
- DONE: core_rst_n=1, held until the next start. ERR: core_rst_n stays 0.
- start while busy is ignored.
- s_valid outside HDR/DATA/CSUM is ignored; no byte is consumed.
- mem_addr arithmetic is AW bits wide; k < DEPTH guarantees no wrap.
- Asynchronous reset mid-load:
  - immediate return to IDLE, all outputs 0.
  - the partial image is not invalidated in memory, but core_rst_n stays 0.
- Checksum covers the header bytes, so a corrupted length is detected unless it already trips N > DEPTH.

Decomposition:
- Shared package xr_boot_pkg:
  - loader state enum.
  - BYTES_PER_WORD=4.
  - HDR_BYTES=4.
  - default DEPTH constant, shared with the instruction memory.
- One sub-module, byte_packer:
  - 8-to-32 little-endian shift register with a 2-bit byte counter.
  - emits word_valid on the 4th byte.
  - clear input driven by the FSM.
- The FSM, word counter, address generation and checksum stay in inst_loader.

Test Plan:
- Basic load: start, then N=2 (02 00 00 00), words 0x00500093 and 0x00100113 sent little-endian, correct checksum.
  -> mem_we at addr 0x0 with 0x00500093, then at addr 0x4 with 0x00100113; DONE; core_rst_n=1.
- Bad checksum: same image, checksum byte inverted.
  -> both words still written; ERR; core_rst_n=0; err=1.
- Oversize image: N=4097.
  -> ERR immediately after the 4th header byte; no mem_we; s_ready drops.
- Empty image: N=0 plus checksum 0x00.
  -> no mem_we; DONE.
- Gaps and restart: s_valid toggled randomly during DATA, and start pulsed mid-load.
  -> words identical to the gap-free case; the mid-load start is ignored.
- Reset mid-load: rst_n asserted after 6 payload bytes.
  -> all outputs 0 asynchronously; a later start with a clean image reaches DONE and the first write is at addr 0.
